fme_half_sel: RTL
=================

# fme_half_sel

Half-pel decision stage of the FME path, directly downstream of the half-pel interpolator. Per current-block pixel it takes the 9 half-pel candidate samples (3x3 grid around the integer position, index 4 = integer centre), accumulates one SAD per candidate against the current pixel over a block, then selects the minimum-cost candidate. It emits the winning index, its SAD and the half-pel MV refinement (dx, dy) to the quarter-pel stage.

## Interface
- BLK_PIXELS, 16, pixels per block (power of two, ≥2)
- SAD_W, 8 + $clog2(BLK_PIXELS) (derived localparam), SAD/accumulator width
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  candidate beat valid
- in_ready  output  1  block accepts a beat
- cand  input  [8:0][7:0]  half-pel candidates, row-major 3x3, cand[4] = integer pixel
- cur  input  8  current-block pixel co-located with cand
- out_valid  output  1  decision valid
- out_ready  input  1  consumer accepts decision
- best_idx  output  4  winning candidate index 0..8
- best_sad  output  SAD_W  SAD of winner
- mv_dx  output  2  signed half-pel x offset (-1..+1)
- mv_dy  output  2  signed half-pel y offset (-1..+1)

## Operation
- States: ACC, CMP, DONE. Reset → ACC.
- ACC: in_ready = 1 (0 while rst high). On in_valid && in_ready: acc[k] += |cand[k] - cur| for k = 0..8; pix_cnt++. Beat accepted with pix_cnt == BLK_PIXELS-1 → pix_cnt = 0, go CMP.
- CMP: 9 cycles, scan idx 0..8 one per cycle. Init best = acc[4], best_idx = 4. Update only on acc[idx] < best (strict). Tie rule: centre wins; otherwise lowest index. After idx 8 → DONE.
- DONE: out_valid = 1; best_idx/best_sad/mv_* held stable. On out_valid && out_ready: clear all acc, out_valid = 0, → ACC.
- MV map: row = idx/3, col = idx%3; mv_dx = col-1, mv_dy = row-1.
- Arithmetic: abs-diff 8-bit unsigned; accumulator SAD_W bits, max BLK_PIXELS*255 fits, no saturation needed.
- in_valid while in_ready = 0: ignored, no state change.
- Reset at any point: acc, pix_cnt, all outputs cleared; partial block discarded.

## Timing
- Reset values: in_ready 0 during rst (1 first cycle after), out_valid 0, best_idx 0, best_sad 0, mv_dx 0, mv_dy 0.
- Last beat accepted at edge T → CMP on cycles T+1..T+9 → out_valid high from cycle after edge T+9 (latency 10 cycles).
- in_ready low from cycle after last beat until cycle after output handshake.
- Output handshake at edge H → in_ready = 1 cycle after H; new block may start immediately; no cycle of overlap between blocks.
- Bubbles on in_valid allowed anywhere; they only stretch ACC.
- All outputs registered; in_ready decoded from state register only.

## Structure
- Package fme_pkg: NUM_CAND = 9, CENTER_IDX = 4, state enum {ACC, CMP, DONE}, function idx→(dx,dy).
- Sub-module fme_sad_lane: one abs-diff + accumulator with clear and enable; 9 instances.
- Top holds FSM, pix_cnt, compare scan, output registers.

## Test plan
- cur = 100 all 16 pixels, cand[k] = 100+k → SAD[k] = 16k; best_idx 0, best_sad 0, mv (-1,-1), out_valid 10 cycles after last beat.
- All cand = cur = 37 → all SAD 0; tie → best_idx 4, best_sad 0, mv (0,0).
- cur = 0, cand[k] = 255 except cand[8] = 254 → SADs 4080 / 4064; best_idx 8, best_sad 4064, mv (+1,+1); no overflow in 12 bits.
- Backpressure: out_ready low 20 cycles after out_valid → outputs stable, in_ready 0, in_valid pulses ignored; raise out_ready → in_ready 1 next cycle.
- rst pulsed after 7 beats, then 16 beats of test 1 data → result identical to test 1 (partial block discarded).
- Random in_valid bubbles with test 1 data → same result; latency still 10 cycles from last accepted beat.

Source files
------------

// File: rtl/fme_pkg.sv
// Shared types and helpers for the half-pel decision stage.
package fme_pkg;

   localparam int NUM_CAND   = 9;
   localparam int CENTER_IDX = 4;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic signed [1:0] dx;
      logic signed [1:0] dy;
   } mv_t;

   // Row-major 3x3 grid: row = idx/3, col = idx%3, offset = position - 1.
   function automatic mv_t idx_to_mv(input logic [3:0] idx);
      mv_t        mv;
      logic [1:0] row;
      logic [1:0] col;
      row = 2'd1;
      col = 2'd1;
      case (idx)
         4'd0: begin row = 2'd0; col = 2'd0; end
         4'd1: begin row = 2'd0; col = 2'd1; end
         4'd2: begin row = 2'd0; col = 2'd2; end
         4'd3: begin row = 2'd1; col = 2'd0; end
         4'd4: begin row = 2'd1; col = 2'd1; end
         4'd5: begin row = 2'd1; col = 2'd2; end
         4'd6: begin row = 2'd2; col = 2'd0; end
         4'd7: begin row = 2'd2; col = 2'd1; end
         4'd8: begin row = 2'd2; col = 2'd2; end
         default: begin row = 2'd1; col = 2'd1; end
      endcase
      mv.dx = col - 2'd1;
      mv.dy = row - 2'd1;
      return mv;
   endfunction

endpackage

// File: rtl/fme_sad_lane.sv
// One SAD lane: 8-bit absolute difference accumulated over a block.
module fme_sad_lane #(
   parameter int SAD_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [7:0]       cand,
   input  logic [7:0]       cur,
   output logic [SAD_W-1:0] acc
);

   logic [7:0] diff;

   assign diff = (cand >= cur) ? (cand - cur) : (cur - cand);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + SAD_W'(diff);
      end
   end

endmodule

// File: rtl/fme_half_sel.sv
// Half-pel decision: per-candidate SAD over a block, then a 9-cycle minimum scan.
//
// state | meaning
// ACC   | accepting candidate beats, accumulating SADs
// CMP   | scanning candidates 0..8 for the minimum SAD
// DONE  | decision presented, waiting for out_ready
module fme_half_sel
   import fme_pkg::*;
#(
   parameter  int BLK_PIXELS = 16,
   localparam int SAD_W      = 8 + $clog2(BLK_PIXELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8:0][7:0]       cand,
   input  logic [7:0]            cur,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            best_idx,
   output logic [SAD_W-1:0]      best_sad,
   output logic signed [1:0]     mv_dx,
   output logic signed [1:0]     mv_dy
);

   localparam int              CNT_W    = $clog2(BLK_PIXELS);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(BLK_PIXELS - 1);
   localparam logic [3:0]      LAST_IDX = 4'(NUM_CAND - 1);
   localparam logic [3:0]      CTR_IDX  = 4'(CENTER_IDX);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  pix_cnt;
   logic [3:0]        scan_idx;
   logic [SAD_W-1:0]  acc [NUM_CAND];
   logic [SAD_W-1:0]  run_sad;
   logic [3:0]        run_idx;
   logic              rdy_q;
   logic              vld_q;
   logic              beat;
   logic              last_beat;
   logic              out_hs;
   logic [SAD_W-1:0]  base_sad;
   logic [3:0]        base_idx;
   logic [SAD_W-1:0]  scan_sad;
   logic [SAD_W-1:0]  win_sad;
   logic [3:0]        win_idx;
   mv_t               win_mv;

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign beat      = in_valid && rdy_q;
   assign last_beat = beat && (pix_cnt == LAST_PIX);
   assign out_hs    = vld_q && out_ready;

   for (genvar k = 0; k < NUM_CAND; k++) begin : g_lane
      fme_sad_lane #(.SAD_W(SAD_W)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .clr  (out_hs),
         .en   (beat),
         .cand (cand[k]),
         .cur  (cur),
         .acc  (acc[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (last_beat) state_nxt = CMP;
         CMP:     if (scan_idx == LAST_IDX) state_nxt = DONE;
         DONE:    if (out_hs) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   // Scan seeds from the centre so a tie with the integer position keeps it;
   // strict less-than otherwise favours the lowest index.
   always_comb begin
      base_sad = (scan_idx == 4'd0) ? acc[CENTER_IDX] : run_sad;
      base_idx = (scan_idx == 4'd0) ? CTR_IDX : run_idx;
      scan_sad = acc[scan_idx];
      win_sad  = base_sad;
      win_idx  = base_idx;
      if (scan_sad < base_sad) begin
         win_sad = scan_sad;
         win_idx = scan_idx;
      end
      win_mv = idx_to_mv(win_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt  <= '0;
         scan_idx <= '0;
         run_sad  <= '0;
         run_idx  <= '0;
         rdy_q    <= 1'b0;
         vld_q    <= 1'b0;
         best_idx <= '0;
         best_sad <= '0;
         mv_dx    <= '0;
         mv_dy    <= '0;
      end else begin
         rdy_q <= (state_nxt == ACC);
         vld_q <= (state_nxt == DONE);
         if (beat) begin
            pix_cnt <= last_beat ? '0 : pix_cnt + 1'b1;
         end
         if (state == CMP) begin
            run_sad  <= win_sad;
            run_idx  <= win_idx;
            scan_idx <= (scan_idx == LAST_IDX) ? 4'd0 : scan_idx + 4'd1;
            if (scan_idx == LAST_IDX) begin
               best_idx <= win_idx;
               best_sad <= win_sad;
               mv_dx    <= win_mv.dx;
               mv_dy    <= win_mv.dy;
            end
         end
      end
   end

endmodule
